// File: rtl/fifo_rptr_rempty_if.sv
// fifo_rptr_rempty_if: read-side handshake, pointer and status bundle of the async FIFO
interface fifo_rptr_rempty_if #(
  parameter int Address    = 3,
  parameter int Data_width = 8
);
  logic                  Rinc;
  logic [Address:0]      Rq2_wptr;
  logic [Data_width-1:0] Rdata_mem;
  logic [Address-1:0]    Radder;
  logic [Address:0]      Rptr;
  logic                  Rempty;
  logic                  Raempty;
  logic [Address:0]      Rlevel;
  logic [Data_width-1:0] Rdata;
  logic                  Rvalid;
  logic                  Runderflow;
  modport slave (
    input  Rinc, Rq2_wptr, Rdata_mem,
    output Radder, Rptr, Rempty, Raempty, Rlevel, Rdata, Rvalid, Runderflow
  );
  modport master (
    output Rinc, Rq2_wptr, Rdata_mem,
    input  Radder, Rptr, Rempty, Raempty, Rlevel, Rdata, Rvalid, Runderflow
  );
endinterface

// File: rtl/fifo_rptr_rempty.sv
// fifo_rptr_rempty: async FIFO read pointer, empty/almost-empty/level status, data stage and underflow
module fifo_rptr_rempty #(
  parameter int Address       = 3,
  parameter int Data_width    = 8,
  parameter int Aempty_thresh = 1
) (
  input logic Rclk,
  input logic Rrst,
  fifo_rptr_rempty_if.slave bus
);
  localparam logic [Address:0] THR = (Address+1)'(Aempty_thresh);
  logic [Address:0]      rbin_q, rbin_d, rptr_q, rptr_d, level_q, level_d, wbin_s;
  logic                  rempty_q, raempty_q, rvalid_q, runder_q, pop;
  logic [Data_width-1:0] rdata_q;
  always_comb begin
    for (int i = 0; i <= Address; i++) wbin_s[i] = ^(bus.Rq2_wptr >> i);
    pop     = bus.Rinc & ~rempty_q;
    rbin_d  = rbin_q + (Address+1)'(pop);
    rptr_d  = (rbin_d >> 1) ^ rbin_d;
    level_d = wbin_s - rbin_d;
  end
  // full-width Gray compare and modular subtraction keep empty/level correct across the MSB wrap
  always_ff @(posedge Rclk or negedge Rrst)
    if (!Rrst) begin
      rbin_q    <= '0;
      rptr_q    <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      level_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      runder_q  <= 1'b0;
    end else begin
      rbin_q    <= rbin_d;
      rptr_q    <= rptr_d;
      rempty_q  <= rptr_d == bus.Rq2_wptr;
      raempty_q <= level_d <= THR;
      level_q   <= level_d;
      rvalid_q  <= pop;
      if (pop) rdata_q <= bus.Rdata_mem;
      runder_q  <= runder_q | (bus.Rinc & rempty_q);
    end
  assign bus.Radder     = rbin_q[Address-1:0];
  assign bus.Rptr       = rptr_q;
  assign bus.Rempty     = rempty_q;
  assign bus.Raempty    = raempty_q;
  assign bus.Rlevel     = level_q;
  assign bus.Rdata      = rdata_q;
  assign bus.Rvalid     = rvalid_q;
  assign bus.Runderflow = runder_q;
endmodule

// File: tb/tb_fifo_rptr_rempty.sv
// tb_fifo_rptr_rempty: directed and random pops/writes checked against a queue-based FIFO model
module tb_fifo_rptr_rempty;
  localparam int A = 3, DW = 8;
  logic Rclk = 1'b0, Rrst = 1'b0;
  fifo_rptr_rempty_if #(.Address(A), .Data_width(DW)) bus();
  fifo_rptr_rempty #(.Address(A), .Data_width(DW), .Aempty_thresh(1)) dut (
    .Rclk(Rclk), .Rrst(Rrst), .bus(bus)
  );
  always #5 Rclk = ~Rclk;
  logic [DW-1:0] mem [8];
  assign bus.Rdata_mem = mem[bus.Radder];
  int wcnt, rcnt, tests, fails;
  logic [DW-1:0] q [$];
  logic [DW-1:0] m_data;
  bit m_valid, m_under;
  function automatic logic [A:0] gray(int n);
    logic [A:0] b;
    b = (A+1)'(n);
    return b ^ (b >> 1);
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all;
    chk("rptr", 32'(bus.Rptr), 32'(gray(rcnt)));
    chk("radder", 32'(bus.Radder), 32'(rcnt % 8));
    chk("rempty", 32'(bus.Rempty), 32'(q.size() == 0));
    chk("rlevel", 32'(bus.Rlevel), 32'(q.size()));
    chk("raempty", 32'(bus.Raempty), 32'(q.size() <= 1));
    chk("rvalid", 32'(bus.Rvalid), 32'(m_valid));
    chk("rdata", 32'(bus.Rdata), 32'(m_data));
    chk("runderflow", 32'(bus.Runderflow), 32'(m_under));
  endtask
  task automatic step(bit rinc, int nw);
    logic [DW-1:0] d;
    bit pop;
    pop = rinc && q.size() != 0;
    for (int i = 0; i < nw && q.size() < 8; i++) begin
      d = DW'($urandom);
      mem[wcnt % 8] = d;
      q.push_back(d);
      wcnt++;
    end
    bus.Rinc = rinc;
    bus.Rq2_wptr = gray(wcnt);
    m_valid = pop;
    if (pop) begin
      m_data = q.pop_front();
      rcnt++;
    end
    if (rinc && !pop) m_under = 1'b1;
    @(posedge Rclk);
    #1;
    check_all;
  endtask
  task automatic do_reset;
    @(negedge Rclk);
    bus.Rinc = 1'b1;
    bus.Rq2_wptr = '0;
    Rrst = 1'b0;
    #1;
    wcnt = 0; rcnt = 0; q.delete(); m_data = '0; m_valid = 1'b0; m_under = 1'b0;
    check_all;
    @(posedge Rclk);
    #1;
    check_all;
    Rrst = 1'b1;
    bus.Rinc = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    bus.Rinc = 1'b0;
    bus.Rq2_wptr = '0;
    do_reset;
    step(0, 1);
    step(1, 0);
    step(0, 0);
    do_reset;
    step(0, 8);
    for (int i = 0; i < 8; i++) step(1, 0);
    step(0, 4);
    for (int i = 0; i < 4; i++) step(1, 0);
    step(1, 0);
    step(1, 0);
    step(0, 3);
    step(1, 0);
    step(1, 0);
    step(1, 1);
    step(1, 1);
    for (int i = 0; i < 400; i++) step(bit'($urandom % 2), int'($urandom % 3));
    step(0, 5);
    for (int i = 0; i < 3; i++) step(1, 0);
    do_reset;
    for (int i = 0; i < 100; i++) step(bit'($urandom % 4 != 0), int'($urandom % 2));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_rptr_rempty.md
# fifo_rptr_rempty

Read-side pointer and status controller for the asynchronous FIFO, the counterpart of the write-pointer/full block. It runs entirely in the read clock domain and owns the read binary counter, the Gray-coded read pointer exported to the write domain, and the empty flag. It also provides almost-empty and occupancy status, a registered read-data stage with a valid pulse, and sticky underflow detection. It sits between the dual-port FIFO memory (read port) and the read-domain consumer.

## Interface
- `Address`, 3 — pointer address width; FIFO depth = 2^Address; pointers are Address+1 bits.
- `Data_width`, 8 — width of memory read data and of `Rdata`.
- `Aempty_thresh`, 1 — `Raempty` asserts when the occupancy is ≤ this value; legal range 0..2^Address−1.

Ports:
- `Rclk` in 1 — read-domain clock; all state updates on the rising edge.
- `Rrst` in 1 — asynchronous, active-low reset.
- `Rinc` in 1 — pop request from the consumer.
- `Rq2_wptr` in Address+1 — Gray-coded write pointer, already synchronized into `Rclk`.
- `Rdata_mem` in Data_width — memory read data; combinational read at `Radder`.
- `Radder` out Address — memory read address, equal to `rbin[Address-1:0]`.
- `Rptr` out Address+1 — registered Gray-coded read pointer, sent to the write-domain synchronizer.
- `Rempty` out 1 — registered empty flag.
- `Raempty` out 1 — registered almost-empty flag.
- `Rlevel` out Address+1 — registered occupancy, 0..2^Address.
- `Rdata` out Data_width — registered popped word.
- `Rvalid` out 1 — one-cycle pulse: `Rdata` holds a newly popped word.
- `Runderflow` out 1 — sticky flag: a pop was attempted while empty.

## Operation
- **Pop acceptance:** `pop = Rinc & ~Rempty`. The current-cycle `Rempty` is the qualifier.
- **Read counter:**
  - `rbin_next = rbin + pop`, modulo 2^(Address+1).
  - `rgray_next = (rbin_next >> 1) ^ rbin_next`.
  - Each edge: `rbin <= rbin_next`, `Rptr <= rgray_next`.
- **Empty:** `Rempty <= (rgray_next == Rq2_wptr)`, a full-width Gray compare including the MSB.
- **Write-pointer conversion:** `wbin_s = gray2bin(Rq2_wptr)`, where bit i = XOR of `Rq2_wptr[Address:i]`. This logic is combinational.
- **Level:**
  - `level_next = wbin_s − rbin_next`, computed modulo 2^(Address+1). It never exceeds 2^Address.
  - `Rlevel <= level_next`.
  - `Raempty <= (level_next <= Aempty_thresh)`.
- **Data stage:**
  - On `pop`: `Rdata <= Rdata_mem` (word at the old `Radder`) and `Rvalid <= 1`.
  - Otherwise: `Rvalid <= 0` and `Rdata` holds.
- **Underflow:**
  - `Runderflow <= 1` when `Rinc & Rempty`; cleared only by reset.
  - An underflowing request changes no pointer, data or valid state.
- **Reset values (asynchronous, immediate):**
  - `rbin=0`, `Rptr=0`, `Rempty=1`, `Raempty=1`, `Rlevel=0`, `Rdata=0`, `Rvalid=0`, `Runderflow=0`.
- **Reset mid-operation:** all state returns to the reset values regardless of `Rinc`. The write side must be reset concurrently; this block does not check that.
- **Wrap-around:** the pointer MSB toggles every 2^Address pops. Empty and level stay correct across the wrap because both use full-width compare and subtraction.
- **Simultaneous events:**
  - A write arriving in `Rq2_wptr` on the same edge as a pop is taken into the `Rempty`/`Rlevel` computation for that edge.
  - Popping the last word while a new write synchronizes in on the same edge yields `Rempty=0`.
- **Conservatism:** `Rempty` may stay asserted for up to about 2 `Rclk` cycles after a remote write because of synchronizer delay. This is pessimistic and must never report data that is not present.

## Timing
- Pop latency: `Rinc` sampled high with `Rempty=0` at edge N gives `Rdata` and `Rvalid=1` valid after edge N. `Rptr`, `Rempty`, `Rlevel` and `Raempty` also update at edge N.
- Back-to-back pops are supported at one per cycle.
- `Rvalid` pulses once per accepted pop.
- All outputs are registered except `Radder`, which is a direct slice of the registered `rbin`.
- `Rdata_mem` must settle within one `Rclk` period of a `Radder` change.

## Test plan
- **Reset:** assert `Rrst=0` mid-stream after 3 pops → immediately `Rptr=0`, `Rempty=1`, `Raempty=1`, `Rlevel=0`, `Rvalid=0`, `Runderflow=0`.
- **Single word:**
  - Set `Rq2_wptr=4'b0001` (binary 1) and wait one edge → `Rempty=0`, `Rlevel=1`, `Raempty=1`.
  - Pop → `Rdata=Rdata_mem[0]`, `Rvalid` high for one cycle, `Rptr=4'b0001`, `Rempty=1`, `Rlevel=0`.
- **Full drain:**
  - Set `Rq2_wptr=gray(8)=4'b1100` → `Rlevel=8`, `Raempty=0`.
  - Pop 8 times back to back → `Radder` runs 0..7, `Rlevel` runs 7..0, `Raempty` rises at `Rlevel=1`, `Rempty` rises on the 8th pop, `Rptr=4'b1100`.
- **Wrap-around:**
  - Continue with `Rq2_wptr=gray(12)=4'b1010` → `Rlevel=4`.
  - Pop 4 times → `Radder` runs 0..3, final `Rptr=4'b1010`, `Rempty=1`.
- **Underflow:**
  - Hold `Rinc=1` while `Rempty=1` → `Runderflow=1` sticky, `Rptr` unchanged, `Rvalid=0`.
  - Stays 1 after the FIFO refills; clears only on reset.
- **Simultaneous:**
  - With `Rlevel=1`, pop on the same edge that `Rq2_wptr` advances by 1 → `Rempty=0`, `Rlevel=1`, `Rvalid=1`.
